// File: rtl/ysyx_25070198_bus_pkg.sv
// rtl/ysyx_25070198_bus_pkg.sv - shared types and constants for the IFU/LSU bus arbiter
// Contents: arb_state_t (arbiter states), master ids, default timeout read data.
package ysyx_25070198_bus_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GNT_IFU = 2'd1,
    GNT_LSU = 2'd2
  } arb_state_t;

  localparam logic MASTER_IFU = 1'b0;
  localparam logic MASTER_LSU = 1'b1;

  localparam logic [31:0] DEFAULT_ERR_RDATA = 32'hDEADBEEF;

endpackage

// File: rtl/ysyx_25070198_bus_if.sv
// rtl/ysyx_25070198_bus_if.sv - SimpleBus bundle between IFU, LSU, arbiter and memory
// Signals:
//   io_ifu_*  fetch request (addr) and completion (rdata, respValid)
//   io_lsu_*  load/store request (addr, wen, wdata, wmask) and completion
//   io_mem_*  single memory port: latched request out, rdata/respValid back
//   io_bus_err  watchdog timeout pulse
// Modports:
//   slave   arbiter view (serves IFU/LSU, drives the memory port)
//   master  environment view (IFU/LSU requesters and the memory)
interface ysyx_25070198_bus_if;

  logic        io_ifu_reqValid;
  logic [31:0] io_ifu_addr;
  logic [31:0] io_ifu_rdata;
  logic        io_ifu_respValid;

  logic        io_lsu_reqValid;
  logic [31:0] io_lsu_addr;
  logic        io_lsu_wen;
  logic [31:0] io_lsu_wdata;
  logic [3:0]  io_lsu_wmask;
  logic [31:0] io_lsu_rdata;
  logic        io_lsu_respValid;

  logic        io_mem_reqValid;
  logic [31:0] io_mem_addr;
  logic        io_mem_wen;
  logic [31:0] io_mem_wdata;
  logic [3:0]  io_mem_wmask;
  logic [31:0] io_mem_rdata;
  logic        io_mem_respValid;

  logic        io_bus_err;

  modport slave (
    input  io_ifu_reqValid, io_ifu_addr,
    output io_ifu_rdata, io_ifu_respValid,
    input  io_lsu_reqValid, io_lsu_addr, io_lsu_wen, io_lsu_wdata, io_lsu_wmask,
    output io_lsu_rdata, io_lsu_respValid,
    output io_mem_reqValid, io_mem_addr, io_mem_wen, io_mem_wdata, io_mem_wmask,
    input  io_mem_rdata, io_mem_respValid,
    output io_bus_err
  );

  modport master (
    output io_ifu_reqValid, io_ifu_addr,
    input  io_ifu_rdata, io_ifu_respValid,
    output io_lsu_reqValid, io_lsu_addr, io_lsu_wen, io_lsu_wdata, io_lsu_wmask,
    input  io_lsu_rdata, io_lsu_respValid,
    input  io_mem_reqValid, io_mem_addr, io_mem_wen, io_mem_wdata, io_mem_wmask,
    output io_mem_rdata, io_mem_respValid,
    input  io_bus_err
  );

endinterface

// File: rtl/ysyx_25070198_bus_watchdog.sv
// rtl/ysyx_25070198_bus_watchdog.sv - saturating grant-cycle counter for hung transactions
// Ports:
//   clock, reset  clock and asynchronous active-low reset
//   clear         hold the count at zero (arbiter idle)
//   enable        count one grant cycle
//   expired       count has reached TIMEOUT-1
module ysyx_25070198_bus_watchdog #(
  parameter int TIMEOUT = 256
) (
  input  logic clock,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int CW = $clog2(TIMEOUT);
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);

  logic [CW-1:0] count;

  // Count reads k-1 in the k-th grant cycle because it is held at zero while idle.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable && (count != LAST)) begin
      count <= count + 1'b1;
    end
  end

  assign expired = (count == LAST);

endmodule

// File: rtl/ysyx_25070198_bus_arbiter.sv
// rtl/ysyx_25070198_bus_arbiter.sv - two-master (IFU/LSU) arbiter owning the single memory port
// Ports:
//   clock  single clock
//   reset  asynchronous active-low reset
//   bus    ysyx_25070198_bus_if.slave: IFU/LSU requests and completions,
//          latched memory request, memory response, watchdog error pulse
module ysyx_25070198_bus_arbiter
  import ysyx_25070198_bus_pkg::*;
#(
  parameter int          TIMEOUT   = 256,
  parameter logic [31:0] ERR_RDATA = DEFAULT_ERR_RDATA
) (
  input logic                  clock,
  input logic                  reset,
  ysyx_25070198_bus_if.slave   bus
);

  localparam logic [1:0] S_IDLE    = 2'(IDLE);
  localparam logic [1:0] S_GNT_IFU = 2'(GNT_IFU);
  localparam logic [1:0] S_GNT_LSU = 2'(GNT_LSU);

  logic [1:0]  state;
  logic        last_grant;
  logic [31:0] lat_addr;
  logic        lat_wen;
  logic [31:0] lat_wdata;
  logic [3:0]  lat_wmask;

  logic        in_grant;
  logic        granted;
  logic        ifu_wins;
  logic        lsu_wins;
  logic        expired;
  logic        finish_ok;
  logic        timeout;
  logic        finish;
  logic [31:0] resp_data;

  ysyx_25070198_bus_watchdog #(
    .TIMEOUT(TIMEOUT)
  ) u_watchdog (
    .clock  (clock),
    .reset  (reset),
    .clear  (!in_grant),
    .enable (in_grant),
    .expired(expired)
  );

  always_comb begin
    in_grant  = (state != S_IDLE);
    granted   = (state == S_GNT_LSU) ? MASTER_LSU : MASTER_IFU;
    // On contention the master that was not served last wins.
    ifu_wins  = bus.io_ifu_reqValid && (!bus.io_lsu_reqValid || (last_grant == MASTER_LSU));
    lsu_wins  = bus.io_lsu_reqValid && (!bus.io_ifu_reqValid || (last_grant == MASTER_IFU));
    // A real response in the expiry cycle takes precedence over the timeout.
    finish_ok = in_grant && bus.io_mem_respValid;
    timeout   = in_grant && expired && !bus.io_mem_respValid;
    finish    = finish_ok || timeout;
    resp_data = finish_ok ? bus.io_mem_rdata : ERR_RDATA;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state      <= S_IDLE;
      last_grant <= MASTER_IFU;
      lat_addr   <= '0;
      lat_wen    <= 1'b0;
      lat_wdata  <= '0;
      lat_wmask  <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (lsu_wins) begin
            state     <= S_GNT_LSU;
            lat_addr  <= bus.io_lsu_addr;
            lat_wen   <= bus.io_lsu_wen;
            lat_wdata <= bus.io_lsu_wdata;
            lat_wmask <= bus.io_lsu_wmask;
          end else if (ifu_wins) begin
            state     <= S_GNT_IFU;
            lat_addr  <= bus.io_ifu_addr;
            lat_wen   <= 1'b0;
            lat_wdata <= '0;
            lat_wmask <= '0;
          end
        end
        // Grant states (and the unused encoding, which the watchdog drains back to idle).
        default: begin
          if (finish) begin
            state      <= S_IDLE;
            last_grant <= granted;
          end
        end
      endcase
    end
  end

  // Memory port shows the latched request only while granted; everything is zero when idle.
  assign bus.io_mem_reqValid  = in_grant;
  assign bus.io_mem_addr      = in_grant ? lat_addr  : 32'h0;
  assign bus.io_mem_wen       = in_grant && lat_wen;
  assign bus.io_mem_wdata     = in_grant ? lat_wdata : 32'h0;
  assign bus.io_mem_wmask     = in_grant ? lat_wmask : 4'h0;

  assign bus.io_ifu_respValid = finish && (state == S_GNT_IFU);
  assign bus.io_lsu_respValid = finish && (state == S_GNT_LSU);
  assign bus.io_ifu_rdata     = bus.io_ifu_respValid ? resp_data : 32'h0;
  assign bus.io_lsu_rdata     = bus.io_lsu_respValid ? resp_data : 32'h0;
  assign bus.io_bus_err       = timeout;

endmodule
